rst_seq_ctrl: RTL and testbench



---
 rtl/rst_seq_ctrl_if.sv | 30 +++
 rtl/rst_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rst_seq_ctrl_if.sv
// Reset sequencer bus: PLL lock / soft-reset requests in, per-block resets and status out.
interface rst_seq_ctrl_if;
  logic       pll_locked;
  logic       soft_rst_req;
  logic       phy_rst_n;
  logic       mac_rst_n;
  logic       udp_rst_n;
  logic       init_done;
  logic [2:0] seq_state;

  modport master (
    output pll_locked,
    output soft_rst_req,
    input  phy_rst_n,
    input  mac_rst_n,
    input  udp_rst_n,
    input  init_done,
    input  seq_state
  );

  modport slave (
    input  pll_locked,
    input  soft_rst_req,
    output phy_rst_n,
    output mac_rst_n,
    output udp_rst_n,
    output init_done,
    output seq_state
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Power-up / soft reset sequencer for the UDP/IP stack.
// Waits for a stable PLL lock, then releases PHY, MAC and UDP resets in order
// with programmable gaps. A soft reset re-runs MAC/UDP release with PHY kept up.
module rst_seq_ctrl #(
  parameter int unsigned LOCK_CYC     = 16,
  parameter int unsigned PHY_RST_CYC  = 1000,
  parameter int unsigned PHY_WAIT_CYC = 500,
  parameter int unsigned MAC_WAIT_CYC = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  rst_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PHY_HOLD = 3'd1,
    PHY_WAIT = 3'd2,
    MAC_WAIT = 3'd3,
    RUN      = 3'd4
  } state_t;

  // Terminal counts; the shared counter only ever compares for equality.
  localparam logic [CNT_W-1:0] LOCK_LAST     = CNT_W'(LOCK_CYC - 1);
  localparam logic [CNT_W-1:0] PHY_RST_LAST  = CNT_W'(PHY_RST_CYC - 1);
  localparam logic [CNT_W-1:0] PHY_WAIT_LAST = CNT_W'(PHY_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] MAC_WAIT_LAST = CNT_W'(MAC_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phy_q, phy_d;
  logic             mac_q, mac_d;
  logic             udp_q, udp_d;
  logic             done_q, done_d;

  // State, counter and registered reset outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phy_q   <= 1'b0;
      mac_q   <= 1'b0;
      udp_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phy_q   <= phy_d;
      mac_q   <= mac_d;
      udp_q   <= udp_d;
      done_q  <= done_d;
    end
  end

  // Next state: lock loss beats soft reset, which beats normal counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phy_d   = phy_q;
    mac_d   = mac_q;
    udp_d   = udp_q;
    done_d  = done_q;

    if (state_q != IDLE && !bus.pll_locked) begin
      // All resets reassert together in one edge.
      state_d = IDLE;
      cnt_d   = '0;
      phy_d   = 1'b0;
      mac_d   = 1'b0;
      udp_d   = 1'b0;
      done_d  = 1'b0;
    end else if (state_q == RUN && bus.soft_rst_req) begin
      // PHY stays out of reset; resume sequencing at the MAC release gap.
      state_d = PHY_WAIT;
      cnt_d   = '0;
      mac_d   = 1'b0;
      udp_d   = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          phy_d  = 1'b0;
          mac_d  = 1'b0;
          udp_d  = 1'b0;
          done_d = 1'b0;
          if (!bus.pll_locked) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = PHY_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        PHY_HOLD: begin
          phy_d = 1'b0;
          if (cnt_q == PHY_RST_LAST) begin
            phy_d   = 1'b1;
            cnt_d   = '0;
            state_d = PHY_WAIT;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        PHY_WAIT: begin
          if (cnt_q == PHY_WAIT_LAST) begin
            mac_d   = 1'b1;
            cnt_d   = '0;
            state_d = MAC_WAIT;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        MAC_WAIT: begin
          if (cnt_q == MAC_WAIT_LAST) begin
            udp_d   = 1'b1;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        RUN: begin
          cnt_d = '0;
        end
        default: begin
          // Encodings 5-7 are unreachable in normal operation; recover safely.
          state_d = IDLE;
          cnt_d   = '0;
          phy_d   = 1'b0;
          mac_d   = 1'b0;
          udp_d   = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign bus.phy_rst_n = phy_q;
  assign bus.mac_rst_n = mac_q;
  assign bus.udp_rst_n = udp_q;
  assign bus.init_done = done_q;
  assign bus.seq_state = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Testbench for rst_seq_ctrl: vector table, hand sequences and random stress
// against a timeline model of the release sequence.
module tb_rst_seq_ctrl;

  localparam int LOCK = 4;
  localparam int PRC  = 10;
  localparam int PWC  = 5;
  localparam int MWC  = 3;
  localparam int TOT  = PRC + PWC + MWC;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rst_seq_ctrl_if bus();

  rst_seq_ctrl #(
    .LOCK_CYC    (LOCK),
    .PHY_RST_CYC (PRC),
    .PHY_WAIT_CYC(PWC),
    .MAC_WAIT_CYC(MWC),
    .CNT_W       (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: either idle counting consecutive lock cycles, or at position m_p
  // on the release timeline (edges since leaving idle, saturating at TOT).
  bit m_idle = 1'b1;
  int m_r    = 0;
  int m_p    = 0;

  typedef struct {
    int         n;
    bit         r;
    bit         p;
    bit         s;
    logic [6:0] exp;   // {phy, mac, udp, done, state[2:0]}
  } vec_t;

  vec_t tbl[32];
  int   nv = 0;

  function automatic logic [6:0] model_out();
    logic [2:0] st;
    if (m_idle) return 7'b0000_000;
    if (m_p < PRC)            st = 3'd1;
    else if (m_p < PRC + PWC) st = 3'd2;
    else if (m_p < TOT)       st = 3'd3;
    else                      st = 3'd4;
    return {(m_p >= PRC), (m_p >= PRC + PWC), (m_p >= TOT), (m_p >= TOT), st};
  endfunction

  task automatic model_edge(input bit r, input bit p, input bit s);
    if (!r) begin
      m_idle = 1'b1; m_r = 0;
    end else if (!m_idle && !p) begin
      m_idle = 1'b1; m_r = 0;
    end else if (!m_idle && m_p == TOT && s) begin
      m_p = PRC;
    end else if (m_idle) begin
      if (!p) m_r = 0;
      else if (m_r == LOCK - 1) begin m_idle = 1'b0; m_p = 0; end
      else m_r++;
    end else if (m_p < TOT) begin
      m_p++;
    end
  endtask

  function automatic logic [6:0] dut_out();
    return {bus.phy_rst_n, bus.mac_rst_n, bus.udp_rst_n, bus.init_done, bus.seq_state};
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic check_bit(input string name, input logic cond);
    checks++;
    if (cond !== 1'b1) begin
      errors++;
      $display("FAIL %s got=%b want=1 outs=%b", name, cond, dut_out());
    end
  endtask

  // One clock edge with the given inputs, then compare against the model.
  task automatic step(input bit r, input bit p, input bit s);
    rst_n            = r;
    bus.pll_locked   = p;
    bus.soft_rst_req = s;
    @(posedge clk);
    model_edge(r, p, s);
    @(negedge clk);
    check("model", dut_out(), model_out());
    check_bit("udp_implies_mac", !bus.udp_rst_n || bus.mac_rst_n);
    check_bit("mac_implies_phy", !bus.mac_rst_n || bus.phy_rst_n);
    check_bit("done_is_run", bus.init_done == (bus.seq_state == 3'd4));
  endtask

  task automatic add(input int n, input bit r, input bit p, input bit s, input logic [6:0] e);
    tbl[nv].n = n; tbl[nv].r = r; tbl[nv].p = p; tbl[nv].s = s; tbl[nv].exp = e;
    nv++;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.pll_locked   = 1'b0;
    bus.soft_rst_req = 1'b0;

    // Power-up with steady lock
    add(2,  0, 1, 0, 7'b0000_000);
    add(3,  1, 1, 0, 7'b0000_000);
    add(1,  1, 1, 0, 7'b0000_001);
    add(9,  1, 1, 0, 7'b0000_001);
    add(1,  1, 1, 0, 7'b1000_010);
    add(4,  1, 1, 0, 7'b1000_010);
    add(1,  1, 1, 0, 7'b1100_011);
    add(2,  1, 1, 0, 7'b1100_011);
    add(1,  1, 1, 0, 7'b1111_100);
    add(5,  1, 1, 0, 7'b1111_100);
    // Soft reset from RUN
    add(1,  1, 1, 1, 7'b1000_010);
    add(4,  1, 1, 0, 7'b1000_010);
    add(1,  1, 1, 0, 7'b1100_011);
    add(2,  1, 1, 0, 7'b1100_011);
    add(1,  1, 1, 0, 7'b1111_100);
    // Lock loss in PHY_WAIT, then full replay
    add(1,  0, 1, 0, 7'b0000_000);
    add(14, 1, 1, 0, 7'b1000_010);
    add(2,  1, 1, 0, 7'b1000_010);
    add(1,  1, 0, 0, 7'b0000_000);
    add(13, 1, 1, 0, 7'b0000_001);
    add(1,  1, 1, 0, 7'b1000_010);
    add(5,  1, 1, 0, 7'b1100_011);
    add(3,  1, 1, 0, 7'b1111_100);
    // Lock glitch during lock counting restarts the count
    add(1,  0, 1, 0, 7'b0000_000);
    add(3,  1, 1, 0, 7'b0000_000);
    add(1,  1, 0, 0, 7'b0000_000);
    add(3,  1, 1, 0, 7'b0000_000);
    add(1,  1, 1, 0, 7'b0000_001);
    add(9,  1, 1, 0, 7'b0000_001);
    add(1,  1, 1, 0, 7'b1000_010);

    for (int i = 0; i < nv; i++) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].r, tbl[i].p, tbl[i].s);
      check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
    end

    // Reset beats lock loss and soft request in MAC_WAIT
    step(0, 1, 0);
    repeat (19) step(1, 1, 0);
    check("reach_mac_wait", dut_out(), 7'b1100_011);
    step(1, 1, 0);
    step(0, 0, 1);
    check("rst_priority", dut_out(), 7'b0000_000);

    // Soft request during PHY_HOLD has no effect on timing
    repeat (4) step(1, 1, 0);
    check("phy_hold_entry", dut_out(), 7'b0000_001);
    step(1, 1, 1);
    check("soft_in_hold", dut_out(), 7'b0000_001);
    repeat (8) step(1, 1, 0);
    check("phy_edge13", dut_out(), 7'b0000_001);
    step(1, 1, 0);
    check("phy_edge14", dut_out(), 7'b1000_010);

    // Random stress
    step(0, 1, 0);
    for (int c = 0; c < 10000; c++) begin
      step(($urandom_range(1999) != 0), ($urandom_range(299) != 0), ($urandom_range(39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
